// File: rtl/frame_demux8_pkg.sv
// Shared constants and FSM state type for the frame_demux8 1-to-8 word distributor.
package frame_demux8_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/frame_demux8_if.sv
// Word-in / frame-out handshake bundle for frame_demux8; slave is the block, master the surroundings.
interface frame_demux8_if #(
  parameter int W = 4
);
  import frame_demux8_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y0, y1, y2, y3, y4, y5, y6, y7;
  logic             dup_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, y0, y1, y2, y3, y4, y5, y6, y7, dup_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, y0, y1, y2, y3, y4, y5, y6, y7, dup_err
  );

endinterface

// File: rtl/demux8_dec.sv
// Combinational 3-to-8 one-hot decoder with enable; produces per-channel write strobes.
module demux8_dec
  import frame_demux8_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NCH-1:0]   onehot
);

  always_comb begin
    // NOTE: the default assignment first covers every path, so no latch is inferred.
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/frame_demux8.sv
// Steers a handshaked word stream into eight channel registers and presents the completed frame.
// Optional DEMUX_ADDR_EN: route by in_sel with write-mask completion and sticky dup_err.
module frame_demux8
  import frame_demux8_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  frame_demux8_if.slave  bus
);

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     ch [NCH];
  logic             accept;
  logic             last;
  logic [SEL_W-1:0] dest;
  logic [NCH-1:0]   we;

  assign accept = bus.in_valid & in_ready_q;

`ifdef DEMUX_ADDR_EN
  logic [NCH-1:0] mask;
  logic           dup_q;

  assign dest = bus.in_sel;
  assign last = ((mask | we) == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask  <= '0;
      dup_q <= 1'b0;
    end else if (accept) begin
      mask <= mask | we;
      if ((mask & we) != '0) dup_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      mask <= '0;
    end
  end

  assign bus.dup_err = dup_q;
`else
  logic [SEL_W-1:0] cnt;

  assign dest = cnt;
  assign last = (cnt == SEL_W'(NCH - 1));

  // Wraps 7->0 on the frame-completing accept, so it is already 0 on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  end

  assign bus.dup_err = 1'b0;
`endif

  demux8_dec u_dec (
    .sel    (dest),
    .en     (accept),
    .onehot (we)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: if (accept && last) begin
          state       <= HOLD;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
        end
        HOLD: if (bus.out_ready) begin
          state       <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: begin
          state       <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the channel array is reset explicitly because its contents are visible outputs from reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) ch[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) if (we[i]) ch[i] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y0 = ch[0];
  assign bus.y1 = ch[1];
  assign bus.y2 = ch[2];
  assign bus.y3 = ch[3];
  assign bus.y4 = ch[4];
  assign bus.y5 = ch[5];
  assign bus.y6 = ch[6];
  assign bus.y7 = ch[7];

endmodule

// File: tb/tb_frame_demux8.sv
// Self-checking bench for frame_demux8: directed steps plus random traffic against a frame-level model.
module tb_frame_demux8;
  import frame_demux8_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n;

  frame_demux8_if #(.W(W)) bus ();

  frame_demux8 #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: frame held or filling, number of accepts in this frame, channel contents, written set.
  bit           m_hold;
  int           m_n;
  logic [W-1:0] m_ch [NCH];
  bit   [NCH-1:0] m_mask;
  bit           m_dup;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] fill_words [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_y(input int i);
    case (i)
      0: return bus.y0;
      1: return bus.y1;
      2: return bus.y2;
      3: return bus.y3;
      4: return bus.y4;
      5: return bus.y5;
      6: return bus.y6;
      default: return bus.y7;
    endcase
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_n    = 0;
    m_mask = '0;
    m_dup  = 1'b0;
    for (int i = 0; i < NCH; i++) m_ch[i] = '0;
  endtask

  task automatic model_edge(input bit v, input logic [W-1:0] d, input int s, input bit r);
    int dst;
    if (!m_hold) begin
      if (v) begin
`ifdef DEMUX_ADDR_EN
        dst = s;
        if (m_mask[dst]) m_dup = 1'b1;
`else
        dst = m_n % NCH;
`endif
        m_ch[dst]   = d;
        m_mask[dst] = 1'b1;
        m_n++;
`ifdef DEMUX_ADDR_EN
        if (m_mask == '1) m_hold = 1'b1;
`else
        if (m_n == NCH) m_hold = 1'b1;
`endif
      end
    end else if (r) begin
      m_hold = 1'b0;
      m_n    = 0;
      m_mask = '0;
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'(!m_hold));
    chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(m_hold));
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s.y%0d", tag, i), 32'(dut_y(i)), 32'(m_ch[i]));
    chk($sformatf("%s.dup_err", tag), 32'(bus.dup_err), 32'(m_dup));
  endtask

  task automatic step(input string tag, input bit v, input logic [W-1:0] d, input int s, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = SEL_W'(s);
    bus.out_ready = r;
    @(posedge clk);
    model_edge(v, d, s, r);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    bit v, r;
    logic [W-1:0] d;

    fill_words[0] = 4'hF; fill_words[1] = 4'hE; fill_words[2] = 4'hD; fill_words[3] = 4'hB;
    fill_words[4] = 4'h7; fill_words[5] = 4'hC; fill_words[6] = 4'hA; fill_words[7] = 4'hC;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    model_reset();
    #12;
    check_all("por");
    reset_n = 1'b1;

    // Gapless fill with out_ready low.
    for (int i = 0; i < NCH; i++) step("fill", 1'b1, fill_words[i], i, 1'b0);
    chk("fill.y0_const", 32'(bus.y0), 32'hF);
    chk("fill.y6_const", 32'(bus.y6), 32'hA);
    chk("fill.y7_const", 32'(bus.y7), 32'hC);
    chk("fill.out_valid_const", 32'(bus.out_valid), 32'h1);

    // Back-pressure: source keeps offering 3 while the frame is held.
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 4'h3, 0, 1'b0);
    chk("hold.y0_const", 32'(bus.y0), 32'hF);
    chk("hold.in_ready_const", 32'(bus.in_ready), 32'h0);
    step("release", 1'b1, 4'h3, 0, 1'b1);
    chk("release.y0_kept", 32'(bus.y0), 32'hF);
    step("next0", 1'b1, 4'h3, 0, 1'b1);
    chk("next0.y0_const", 32'(bus.y0), 32'h3);

    // Two more accepts then reset mid-frame; next word lands in y0.
    step("partial", 1'b1, 4'h5, 1, 1'b0);
    step("partial", 1'b1, 4'h6, 2, 1'b0);
    async_reset("midreset");
    step("after_reset", 1'b1, 4'h9, 0, 1'b0);
    chk("after_reset.y0_const", 32'(bus.y0), 32'h9);
    chk("after_reset.y1_const", 32'(bus.y1), 32'h0);
    async_reset("reset2");

    // Same frame with bubbles between words.
    for (int i = 0; i < NCH; i++) begin
      step("gap_bubble", 1'b0, 4'h0, 0, 1'b0);
      step("gap_word", 1'b1, fill_words[i], i, 1'b0);
      if (i == NCH - 2) chk("gap.not_done_at_7", 32'(bus.out_valid), 32'h0);
    end
    for (int i = 0; i < NCH; i++)
      chk($sformatf("gap.frame_y%0d", i), 32'(dut_y(i)), 32'(fill_words[i]));
    step("gap_release", 1'b0, 4'h0, 0, 1'b1);

`ifdef DEMUX_ADDR_EN
    begin
      int sels [NCH] = '{7, 0, 6, 1, 5, 2, 4, 3};
      for (int i = 0; i < NCH; i++) step("addr", 1'b1, W'(i + 1), sels[i], 1'b0);
      chk("addr.out_valid_const", 32'(bus.out_valid), 32'h1);
      chk("addr.y7_const", 32'(bus.y7), 32'h1);
      chk("addr.y3_const", 32'(bus.y3), 32'h8);
      chk("addr.dup_const", 32'(bus.dup_err), 32'h0);
      step("addr_release", 1'b0, 4'h0, 0, 1'b1);
    end
    step("dup", 1'b1, 4'h1, 2, 1'b0);
    step("dup", 1'b1, 4'h9, 2, 1'b0);
    chk("dup.out_valid_const", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < NCH; i++) if (i != 2) step("dup_rest", 1'b1, W'(i), i, 1'b0);
    chk("dup.y2_const", 32'(bus.y2), 32'h9);
    chk("dup.err_const", 32'(bus.dup_err), 32'h1);
    step("dup_release", 1'b0, 4'h0, 0, 1'b1);
    chk("dup.sticky_const", 32'(bus.dup_err), 32'h1);
`endif

    // Peak throughput: two frames in 18 cycles with both sides always ready.
    begin
      int frames = 0;
      for (int i = 0; i < 2 * (NCH + 1); i++) begin
        step("peak", 1'b1, W'($urandom), i % NCH, 1'b1);
        if (bus.out_valid) frames++;
      end
`ifndef DEMUX_ADDR_EN
      chk("peak.frames", 32'(frames), 32'd2);
`endif
    end

    // Random traffic with random bubbles and back-pressure.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      d = W'($urandom);
      step("rand", v, d, int'($urandom_range(0, NCH - 1)), r);
      if (i == 200) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
